// File: rtl/key_hold_judge.sv
// Key hold judge: arms on start, reports hit after a key is held long enough, miss on timeout.
// Optional macro WRONG_KEY_MISS_EN: a non-zero wrong key in WAIT/HOLD ends the judgement with miss.
module key_hold_judge #(
  parameter int unsigned KEY_W          = 4,
  parameter int unsigned HOLD_CYCLES    = 10_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 300_000_000,
  parameter int unsigned CNT_W          = 29
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] correct_key,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             hit,
  output logic             miss,
  output logic             held
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state, state_nx;
  logic [KEY_W-1:0] target, target_nx;
  logic [CNT_W-1:0] hold_cnt, hold_nx, tmo_cnt, tmo_nx;
  logic [CNT_W-1:0] hold_inc, tmo_inc;
  logic             busy_nx, hit_nx, miss_nx, held_nx;
  logic             match, wrong;

  assign match = (key_in == target);

  // Saturating increments so the counters can never wrap.
  assign hold_inc = (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + CNT_W'(1);
  assign tmo_inc  = (tmo_cnt == CNT_MAX) ? tmo_cnt : tmo_cnt + CNT_W'(1);

`ifdef WRONG_KEY_MISS_EN
  assign wrong = (key_in != '0) && !match;
`else
  assign wrong = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      target   <= '0;
      hold_cnt <= '0;
      tmo_cnt  <= '0;
      busy     <= 1'b0;
      hit      <= 1'b0;
      miss     <= 1'b0;
      held     <= 1'b0;
    end else begin
      state    <= state_nx;
      target   <= target_nx;
      hold_cnt <= hold_nx;
      tmo_cnt  <= tmo_nx;
      busy     <= busy_nx;
      hit      <= hit_nx;
      miss     <= miss_nx;
      held     <= held_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    target_nx = target;
    hold_nx   = hold_cnt;
    tmo_nx    = tmo_cnt;
    hit_nx    = 1'b0;
    miss_nx   = 1'b0;
    held_nx   = held;

    case (state)
      S_IDLE: begin
        held_nx = 1'b0;
        if (start) begin
          target_nx = correct_key;
          hold_nx   = '0;
          tmo_nx    = '0;
          state_nx  = S_WAIT;
        end
      end
      S_WAIT, S_HOLD: begin
        tmo_nx = tmo_inc;
        if (match) begin
          hold_nx  = hold_inc;
          state_nx = S_HOLD;
          if (hold_inc >= HOLD_LIM) begin
            hit_nx   = 1'b1;
            held_nx  = 1'b1;
            state_nx = S_RELEASE;
          end
        end else begin
          hold_nx  = '0;
          state_nx = S_WAIT;
        end
        // A coincident final hold sample takes priority over timeout or wrong key.
        if (!hit_nx && ((tmo_inc >= TMO_LIM) || wrong)) begin
          miss_nx  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_RELEASE: begin
        if (!match) begin
          held_nx  = 1'b0;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    busy_nx = (state_nx != S_IDLE);
  end

endmodule

// File: tb/tb_key_hold_judge.sv
// Scoreboard bench for key_hold_judge with HOLD_CYCLES=4, TIMEOUT_CYCLES=20.
// Expected {busy,hit,miss,held} per cycle is queued when stimulus is driven and popped at the next negedge.
module tb_key_hold_judge;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] correct_key;
  logic [3:0] key_in;
  logic       busy, hit, miss, held;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] exp_q[$];
  logic [3:0] e;

  key_hold_judge #(
    .KEY_W(4), .HOLD_CYCLES(4), .TIMEOUT_CYCLES(20), .CNT_W(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .correct_key(correct_key),
    .key_in(key_in), .busy(busy), .hit(hit), .miss(miss), .held(held)
  );

  always #5 clk = ~clk;

  // Expected outputs of cycle n for a single judgement (start accepted in cycle 0).
  function automatic logic [3:0] exp_of(int n, int b1, int hc, int mc, int h0, int h1);
    return {(n >= 1 && n < b1), (n == hc), (n == mc), (n >= h0 && n < h1)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; correct_key = 4'd5; key_in = 4'd5;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, hit, miss, held} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset: got %b want 0000", {busy, hit, miss, held});
    end
    start = 1'b0; key_in = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy, hit, miss, held} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 0000", {busy, hit, miss, held});
    end
  endtask

  // Hit at cycle 7, key held to 10, released in 11, start in 9 ignored.
  task automatic test_basic_hit_release();
    exp_q.push_back(exp_of(0, 12, 7, -1, 7, 12));
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      e = exp_q.pop_front(); n_tests++;
      if ({busy, hit, miss, held} !== e) begin
        n_fail++;
        $display("FAIL basic_hit cycle %0d: got %b want %b", n, {busy, hit, miss, held}, e);
      end
      start = (n == 0) || (n == 9);
      correct_key = 4'd5;
      key_in = (n >= 3 && n <= 10) ? 4'd5 : 4'd0;
      exp_q.push_back(exp_of(n + 1, 12, 7, -1, 7, 12));
    end
    exp_q.delete();
  endtask

  task automatic test_broken_hold();
    exp_q.push_back(exp_of(0, 15, 12, -1, 12, 15));
    for (int n = 0; n < 18; n++) begin
      @(negedge clk);
      e = exp_q.pop_front(); n_tests++;
      if ({busy, hit, miss, held} !== e) begin
        n_fail++;
        $display("FAIL broken_hold cycle %0d: got %b want %b", n, {busy, hit, miss, held}, e);
      end
      start = (n == 0);
      correct_key = 4'd5;
      key_in = ((n >= 3 && n <= 5) || (n >= 8 && n <= 13)) ? 4'd5 : 4'd0;
      exp_q.push_back(exp_of(n + 1, 15, 12, -1, 12, 15));
    end
    exp_q.delete();
  endtask

  task automatic test_timeout_miss();
    exp_q.push_back(exp_of(0, 21, -1, 21, -1, -1));
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      e = exp_q.pop_front(); n_tests++;
      if ({busy, hit, miss, held} !== e) begin
        n_fail++;
        $display("FAIL timeout_miss cycle %0d: got %b want %b", n, {busy, hit, miss, held}, e);
      end
      start = (n == 0);
      correct_key = 4'd5;
      key_in = 4'd0;
      exp_q.push_back(exp_of(n + 1, 21, -1, 21, -1, -1));
    end
    exp_q.delete();
  endtask

  // Final hold sample lands on the final timeout cycle: hit wins.
  task automatic test_timeout_hit();
    exp_q.push_back(exp_of(0, 23, 21, -1, 21, 23));
    for (int n = 0; n < 26; n++) begin
      @(negedge clk);
      e = exp_q.pop_front(); n_tests++;
      if ({busy, hit, miss, held} !== e) begin
        n_fail++;
        $display("FAIL timeout_hit cycle %0d: got %b want %b", n, {busy, hit, miss, held}, e);
      end
      start = (n == 0);
      correct_key = 4'd5;
      key_in = (n >= 17 && n <= 21) ? 4'd5 : 4'd0;
      exp_q.push_back(exp_of(n + 1, 23, 21, -1, 21, 23));
    end
    exp_q.delete();
  endtask

  task automatic test_target_zero();
    exp_q.push_back(exp_of(0, 8, 5, -1, 5, 8));
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      e = exp_q.pop_front(); n_tests++;
      if ({busy, hit, miss, held} !== e) begin
        n_fail++;
        $display("FAIL target_zero cycle %0d: got %b want %b", n, {busy, hit, miss, held}, e);
      end
      start = (n == 0);
      correct_key = 4'd0;
      key_in = (n >= 7 && n <= 8) ? 4'd3 : 4'd0;
      exp_q.push_back(exp_of(n + 1, 8, 5, -1, 5, 8));
    end
    exp_q.delete();
    key_in = 4'd0;
  endtask

  // Reset in cycle 5 aborts silently; restart in cycle 8 hits in cycle 13.
  task automatic test_reset_abort();
    logic [3:0] x;
    for (int n = 0; n < 21; n++) begin
      x = {((n >= 1 && n <= 5) || (n >= 9 && n < 19)), (n == 13), 1'b0, (n >= 13 && n < 19)};
      exp_q.push_back(x);
      @(negedge clk);
      e = exp_q.pop_front(); n_tests++;
      if ({busy, hit, miss, held} !== e) begin
        n_fail++;
        $display("FAIL reset_abort cycle %0d: got %b want %b", n, {busy, hit, miss, held}, e);
      end
      start = (n == 0) || (n == 8);
      correct_key = 4'd5;
      key_in = (n >= 3 && n <= 17) ? 4'd5 : 4'd0;
      rst = (n == 5);
      if (n == 5) begin
        #1;
        n_tests++;
        if ({busy, hit, miss, held} !== 4'b0000) begin
          n_fail++;
          $display("FAIL reset_abort_async: got %b want 0000", {busy, hit, miss, held});
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_wrong_key();
    int b1, mc;
`ifdef WRONG_KEY_MISS_EN
    b1 = 3; mc = 3;
`else
    b1 = 21; mc = 21;
`endif
    exp_q.push_back(exp_of(0, b1, -1, mc, -1, -1));
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      e = exp_q.pop_front(); n_tests++;
      if ({busy, hit, miss, held} !== e) begin
        n_fail++;
        $display("FAIL wrong_key cycle %0d: got %b want %b", n, {busy, hit, miss, held}, e);
      end
      start = (n == 0);
      correct_key = 4'd5;
      key_in = (n == 2) ? 4'd3 : 4'd0;
      exp_q.push_back(exp_of(n + 1, b1, -1, mc, -1, -1));
    end
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; correct_key = 4'd0; key_in = 4'd0;
    test_reset();
    test_basic_hit_release();
    test_broken_hold();
    test_timeout_miss();
    test_timeout_hit();
    test_target_zero();
    test_reset_abort();
    test_wrong_key();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
